// File: rtl/proc_sequencer.sv
// proc_sequencer: four-step control FSM (T0..T3) for a small register-file
// processor. It decodes the instruction register and drives the bus-select,
// register-load and ALU-control strobes. The step register is exported on
// Tstep so checkers can observe FSM state directly.
//
// Optional feature: define PROC_SEQUENCER_MULT_EN to enable opcode 100
// (mult Rx,Ry), which runs through the same three steps as add but with
// MulSel raised in T2. When the macro is undefined, opcode 100 is treated
// as an undefined opcode and MulSel is held at 0.
//
// Handshake: Run is a level request sampled only in T0. When Run=1 in T0,
// IRin is asserted for that cycle and the instruction is committed. From
// then on it runs to completion regardless of Run. Done marks the last
// cycle of the instruction, and the following cycle is T0 again.
module proc_sequencer (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Run,
   input  logic [8:0] IR,
   output logic       IRin,
   output logic [7:0] Rout,
   output logic [7:0] Rin,
   output logic       DINout,
   output logic       Gout,
   output logic       Ain,
   output logic       Gin,
   output logic       AddSub,
   output logic       MulSel,
   output logic       Done,
   output logic [1:0] Tstep
);

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   logic [1:0] state_q, state_d;
   logic [2:0] op;
   logic [7:0] sel_x, sel_y;
   logic       is_alu;

   assign op    = IR[8:6];
   assign sel_x = 8'd1 << IR[5:3];
   assign sel_y = 8'd1 << IR[2:0];

`ifdef PROC_SEQUENCER_MULT_EN
   logic is_mult;
   assign is_mult = (op == OP_MUL);
   assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || is_mult;
`else
   assign is_alu  = (op == OP_ADD) || (op == OP_SUB);
`endif

   // Next-step logic; reset overrides everything and returns to T0
   always_comb begin
      state_d = state_q;
      if (Reset) begin
         state_d = T0;
      end else begin
         case (state_q)
            T0:      state_d = Run ? T1 : T0;
            T1:      state_d = is_alu ? T2 : T0;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
         endcase
      end
   end

   // Step register
   always_ff @(posedge Clock) begin
      state_q <= state_d;
   end

   // Control strobe decode; everything is forced low while Reset is high
   always_comb begin
      IRin   = 1'b0;
      Rout   = 8'h00;
      Rin    = 8'h00;
      DINout = 1'b0;
      Gout   = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      MulSel = 1'b0;
      Done   = 1'b0;
      Tstep  = 2'd0;
      if (!Reset) begin
         Tstep = state_q;
         case (state_q)
            T0: IRin = Run;
            T1: begin
               if (op == OP_MV) begin
                  Rout = sel_y;
                  Rin  = sel_x;
                  Done = 1'b1;
               end else if (op == OP_MVI) begin
                  DINout = 1'b1;
                  Rin    = sel_x;
                  Done   = 1'b1;
               end else if (is_alu) begin
                  Rout = sel_x;
                  Ain  = 1'b1;
               end else begin
                  Done = 1'b1;
               end
            end
            T2: begin
               Rout   = sel_y;
               Gin    = 1'b1;
               AddSub = (op == OP_SUB);
`ifdef PROC_SEQUENCER_MULT_EN
               MulSel = is_mult;
`endif
            end
            T3: begin
               Gout = 1'b1;
               Rin  = sel_x;
               Done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer. A queue-based reference model turns each
// committed instruction into its list of per-cycle output vectors; every
// cycle is compared against the model plus the bus-driver, one-hot and
// Done-width invariants. Directed cases come first, then random traffic.
module tb_proc_sequencer;

   localparam int VW = 26;

`ifdef PROC_SEQUENCER_MULT_EN
   localparam bit MULT_EN = 1'b1;
`else
   localparam bit MULT_EN = 1'b0;
`endif

   logic       Clock;
   logic       Reset;
   logic       Run;
   logic [8:0] IR;
   logic       IRin, DINout, Gout, Ain, Gin, AddSub, MulSel, Done;
   logic [7:0] Rout, Rin;
   logic [1:0] Tstep;

   int errors = 0;
   int checks = 0;
   logic [VW-1:0] exp_q[$];
   logic [8:0]    cur_ir = 9'd0;
   logic          prev_done = 1'b0;

   proc_sequencer dut (
      .Clock (Clock),
      .Reset (Reset),
      .Run   (Run),
      .IR    (IR),
      .IRin  (IRin),
      .Rout  (Rout),
      .Rin   (Rin),
      .DINout(DINout),
      .Gout  (Gout),
      .Ain   (Ain),
      .Gin   (Gin),
      .AddSub(AddSub),
      .MulSel(MulSel),
      .Done  (Done),
      .Tstep (Tstep)
   );

   // clock / reset block
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [VW-1:0] mk(input logic irin, input logic [7:0] ro,
                                        input logic [7:0] ri, input logic din,
                                        input logic gout, input logic ain,
                                        input logic gin, input logic addsub,
                                        input logic mulsel, input logic done,
                                        input logic [1:0] ts);
      return {irin, ro, ri, din, gout, ain, gin, addsub, mulsel, done, ts};
   endfunction

   // Reference model: expand one instruction into its cycles after T0
   task automatic push_instr(input logic [8:0] ir);
      logic [2:0] op;
      logic [7:0] ox, oy;
      op = ir[8:6];
      ox = 8'd1 << ir[5:3];
      oy = 8'd1 << ir[2:0];
      if (op == 3'd0) begin
         exp_q.push_back(mk(0, oy, ox, 0, 0, 0, 0, 0, 0, 1, 2'd1));
      end else if (op == 3'd1) begin
         exp_q.push_back(mk(0, 8'h00, ox, 1, 0, 0, 0, 0, 0, 1, 2'd1));
      end else if (op == 3'd2 || op == 3'd3 || (op == 3'd4 && MULT_EN)) begin
         exp_q.push_back(mk(0, ox, 8'h00, 0, 0, 1, 0, 0, 0, 0, 2'd1));
         exp_q.push_back(mk(0, oy, 8'h00, 0, 0, 0, 1, op == 3'd3, op == 3'd4, 0, 2'd2));
         exp_q.push_back(mk(0, 8'h00, ox, 0, 1, 0, 0, 0, 0, 1, 2'd3));
      end else begin
         exp_q.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2'd1));
      end
   endtask

   task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Driver + scoreboard: apply one cycle of inputs and check outputs mid-cycle
   task automatic step(input logic run, input logic rst);
      logic [VW-1:0] exp, obs;
      int drivers;
      @(posedge Clock);
      #1;
      Run   = run;
      Reset = rst;
      IR    = cur_ir;
      if (rst) begin
         exp_q.delete();
         exp = '0;
      end else if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
      end else begin
         exp = mk(run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2'd0);
         if (run) push_instr(cur_ir);
      end
      @(negedge Clock);
      obs = {IRin, Rout, Rin, DINout, Gout, Ain, Gin, AddSub, MulSel, Done, Tstep};
      check_vec("outputs", obs, exp);
      drivers = int'(Rout != 8'h00) + int'(Gout) + int'(DINout);
      check_bit("single_bus_driver", drivers <= 1, 1'b1);
      check_bit("onehot_rout_rin", $countones(Rout) <= 1 && $countones(Rin) <= 1, 1'b1);
      check_bit("done_width", prev_done && Done, 1'b0);
      prev_done = Done;
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b0;
      IR    = 9'd0;

      // reset and idle
      step(0, 1);
      step(1, 1);
      step(0, 0);

      // mv R1,R0
      cur_ir = 9'd8;
      step(1, 0);
      step(0, 0);
      check_vec("mv_rout", {18'd0, Rout}, {18'd0, 8'h01});
      check_vec("mv_rin", {18'd0, Rin}, {18'd0, 8'h02});
      step(0, 0);
      check_vec("mv_tstep_after", {24'd0, Tstep}, '0);

      // mvi R0, then add R0,R1 back-to-back with Run held high
      cur_ir = 9'd64;
      step(1, 0);
      step(1, 0);
      check_bit("mvi_dinout", DINout, 1'b1);
      cur_ir = 9'd129;
      step(1, 0);
      step(1, 0);
      step(1, 0);
      check_bit("add_t2_addsub", AddSub, 1'b0);
      step(1, 0);
      check_vec("add_t3_rin", {18'd0, Rin}, {18'd0, 8'h01});

      // add R0,R0 with Run dropped mid-instruction
      cur_ir = 9'd128;
      step(1, 0);
      step(0, 0);
      step(0, 0);
      step(0, 0);
      step(0, 0);

      // sub R2,R3 interrupted by Reset in T2
      cur_ir = 9'd211;
      step(1, 0);
      step(0, 0);
      step(0, 1);
      step(0, 0);
      check_bit("sub_no_done_after_reset", Done, 1'b0);
      step(0, 0);
      step(0, 0);

      // mult R4,R4
      cur_ir = 9'd292;
      step(1, 0);
      step(0, 0);
      check_bit("mult_t1_done", Done, !MULT_EN);
      step(0, 0);
      step(0, 0);
      step(0, 0);

      // every opcode, random operands, Run toggling, rare resets
      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0) cur_ir = 9'($urandom_range(0, 511));
         step(1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
